// File: rtl/shift_deserializer_pkg.sv
// Shared types and helpers for the serial-in/parallel-out receiver.
// The PARITY state is always declared; only SHIFT_DESER_PARITY_EN builds use it.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    // Data bits XOR parity bit must equal this for a clean even-parity word.
    localparam logic PARITY_EVEN = 1'b0;

    // Bit counter must hold values 0..WIDTH.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_deserializer_word_hold_reg.sv
// Output holding register: keeps a completed word until the consumer takes it,
// and records a sticky overrun when a new word arrives with nowhere to go.
module word_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             perr_i,
    input  logic             out_ready_i,
    input  logic             clr_overrun_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    output logic             overrun_o,
    output logic             parity_err_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             perr_q, perr_d;
    logic             accept, drop;

    assign accept = valid_q & out_ready_i;
    // A new word only fits if the slot is empty or is being drained this cycle.
    assign drop   = load_i & valid_q & ~out_ready_i;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        if (load_i && !drop) begin
            data_d  = word_i;
            perr_d  = perr_i;
            valid_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
        ovr_d = (ovr_q & ~clr_overrun_i) | drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    assign out_data_o   = data_q;
    assign out_valid_o  = valid_q;
    assign overrun_o    = ovr_q;
    assign parity_err_o = perr_q;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out receiver assembling WIDTH-bit words from a qualified bit stream.
// Define SHIFT_DESER_PARITY_EN to expect a trailing even-parity bit per word.
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in_i,
    input  logic             ser_valid_i,
    input  logic             start_i,
    input  logic             clr_overrun_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             overrun_o,
    output logic             parity_err_o
);

    localparam int CW = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;

    // start wipes the partial word first, so a bit in the same cycle opens a new frame.
    state_e           st_b;
    logic [CW-1:0]    cnt_b;
    logic [WIDTH-1:0] sr_b, sr_sh;

    logic             load;
    logic [WIDTH-1:0] word;
    logic             perr;

    assign st_b  = start_i ? IDLE : state_q;
    assign cnt_b = start_i ? '0   : cnt_q;
    assign sr_b  = start_i ? '0   : sr_q;
    assign sr_sh = MSB_FIRST ? {sr_b[WIDTH-2:0], ser_in_i} : {ser_in_i, sr_b[WIDTH-1:1]};

    always_comb begin
        state_d = st_b;
        cnt_d   = cnt_b;
        sr_d    = sr_b;
        load    = 1'b0;
        word    = sr_sh;
        perr    = 1'b0;
        if (ser_valid_i) begin
            case (st_b)
                IDLE: begin
                    sr_d    = sr_sh;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
                SHIFT: begin
                    sr_d = sr_sh;
                    if (cnt_b == CW'(WIDTH - 1)) begin
`ifdef SHIFT_DESER_PARITY_EN
                        cnt_d   = CW'(WIDTH);
                        state_d = PARITY;
`else
                        cnt_d   = '0;
                        state_d = IDLE;
                        load    = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_b + CW'(1);
                    end
                end
                PARITY: begin
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef SHIFT_DESER_PARITY_EN
                    // Parity bit is not shifted in; the data word is already complete.
                    load    = 1'b1;
                    word    = sr_b;
                    perr    = (^sr_b) ^ ser_in_i ^ PARITY_EVEN;
`endif
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
        end
    end

    assign busy_o = (state_q == SHIFT);

    word_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk          (clk),
        .reset        (reset),
        .load_i       (load),
        .word_i       (word),
        .perr_i       (perr),
        .out_ready_i  (out_ready_i),
        .clr_overrun_i(clr_overrun_i),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .overrun_o    (overrun_o),
        .parity_err_o (parity_err_o)
    );

endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench: drives one bit stream into an MSB-first and an LSB-first instance;
// a monitor pops expected words whenever a handoff occurs.
module tb_shift_deserializer;

`ifdef SHIFT_DESER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, ser_in, ser_valid, start, clr_ov, ready;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, busy_a, busy_b, ovr_a, ovr_b, perr_a, perr_b;

    int checks   = 0;
    int failures = 0;
    bit early_chk = 1'b0;

    logic [8:0] qa[$];
    logic [8:0] qb[$];

    always #5 clk = ~clk;

    shift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset), .ser_in_i(ser_in), .ser_valid_i(ser_valid),
        .start_i(start), .clr_overrun_i(clr_ov), .out_data_o(data_a),
        .out_valid_o(valid_a), .out_ready_i(ready), .busy_o(busy_a),
        .overrun_o(ovr_a), .parity_err_o(perr_a));

    shift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .ser_in_i(ser_in), .ser_valid_i(ser_valid),
        .start_i(start), .clr_overrun_i(clr_ov), .out_data_o(data_b),
        .out_valid_o(valid_b), .out_ready_i(ready), .busy_o(busy_b),
        .overrun_o(ovr_b), .parity_err_o(perr_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handoff must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && valid_a && ready) begin
            if (qa.size() == 0) chk("a_unexpected_word", {perr_a, data_a}, 9'h1ff);
            else chk("a_word", {perr_a, data_a}, qa.pop_front());
        end
        if (!reset && valid_b && ready) begin
            if (qb.size() == 0) chk("b_unexpected_word", {perr_b, data_b}, 9'h1ff);
            else chk("b_word", {perr_b, data_b}, qb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit1(input logic b);
        ser_in    = b;
        ser_valid = 1'b1;
        tick();
        ser_valid = 1'b0;
    endtask

    // Sends v[7] first; raises out_ready just before the final bit when rdy_last is set.
    task automatic send_word(input logic [7:0] v, input logic p, input bit rdy_last);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && !PAR && rdy_last) ready = 1'b1;
            bit1(v[i]);
        end
        if (PAR) begin
            if (early_chk) chk("no_valid_before_parity", valid_a, 1'b0);
            if (rdy_last) ready = 1'b1;
            bit1(p);
        end
    endtask

    function automatic logic exp_perr(input logic [7:0] v, input logic p);
        return PAR ? ((^v) ^ p) : 1'b0;
    endfunction

    initial begin
        reset = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; start = 1'b0; clr_ov = 1'b0; ready = 1'b1;
        tick(); tick();
        chk("rst_outputs_a", {data_a, valid_a, busy_a, ovr_a, perr_a}, 12'h000);
        chk("rst_outputs_b", {data_b, valid_b, busy_b, ovr_b, perr_b}, 12'h000);
        reset = 1'b0;
        tick();

        // A5, LSB-first gives the same palindrome.
        qa.push_back({1'b0, 8'hA5}); qb.push_back({1'b0, 8'hA5});
        bit1(1'b1);
        chk("busy_after_first_bit", busy_a, 1'b1);
        early_chk = 1'b1;
        send_word_tail();
        early_chk = 1'b0;
        chk("valid_after_last_bit", {valid_a, valid_b}, 2'b11);
        chk("busy_after_word", {busy_a, busy_b}, 2'b00);
        chk("data_a5", data_a, 8'hA5);
        tick();
        chk("valid_one_cycle", {valid_a, valid_b}, 2'b00);

        // 1,1,0,0,0,0,0,0
        qa.push_back({1'b0, 8'hC0}); qb.push_back({1'b0, 8'h03});
        send_word(8'hC0, 1'b0, 1'b0);
        tick();

        // Stall the consumer, then overflow.
        ready = 1'b0;
        qa.push_back({1'b0, 8'h3C}); qb.push_back({1'b0, 8'h3C});
        send_word(8'h3C, 1'b0, 1'b0);
        chk("held_3c", {valid_a, data_a}, {1'b1, 8'h3C});
        send_word(8'hF0, 1'b0, 1'b0);
        chk("overrun_set", {ovr_a, ovr_b}, 2'b11);
        chk("kept_3c", data_a, 8'h3C);
        chk("kept_3c_b", data_b, 8'h3C);
        clr_ov = 1'b1; tick(); clr_ov = 1'b0;
        chk("overrun_clr", {ovr_a, ovr_b}, 2'b00);

        // 55 completes on the same edge 3C is consumed.
        qa.push_back({1'b0, 8'h55}); qb.push_back({1'b0, 8'hAA});
        send_word(8'h55, 1'b0, 1'b1);
        chk("swap_valid", {valid_a, valid_b}, 2'b11);
        chk("swap_data", {data_a, data_b}, {8'h55, 8'hAA});
        chk("swap_no_overrun", {ovr_a, ovr_b}, 2'b00);
        tick();
        chk("valid_drops", {valid_a, valid_b}, 2'b00);

        // Five junk bits, then start carrying the first bit of 8'h12.
        qa.push_back({1'b0, 8'h12}); qb.push_back({1'b0, 8'h48});
        for (int i = 0; i < 5; i++) bit1(1'b1);
        start = 1'b1; bit1(1'b0); start = 1'b0;
        chk("busy_after_start_bit", busy_a, 1'b1);
        for (int i = 6; i >= 0; i--) bit1(8'h12 >> i);
        if (PAR) bit1(1'b0);
        chk("start_word", data_a, 8'h12);
        tick();

        // Pending word plus overrun, then reset mid-word.
        ready = 1'b0;
        send_word(8'h0F, 1'b0, 1'b0);
        send_word(8'h0F, 1'b0, 1'b0);
        chk("overrun_before_rst", ovr_a, 1'b1);
        bit1(1'b1); bit1(1'b0); bit1(1'b1);
        reset = 1'b1; tick(); reset = 1'b0;
        ready = 1'b1;
        chk("midword_rst_a", {data_a, valid_a, busy_a, ovr_a, perr_a}, 12'h000);
        chk("midword_rst_b", {data_b, valid_b, busy_b, ovr_b, perr_b}, 12'h000);

        // A5 with a wrong parity bit (flagged only when parity is built in).
        qa.push_back({exp_perr(8'hA5, 1'b1), 8'hA5}); qb.push_back({exp_perr(8'hA5, 1'b1), 8'hA5});
        send_word(8'hA5, 1'b1, 1'b0);
        chk("perr_a5", perr_a, exp_perr(8'hA5, 1'b1));
        tick(); tick();

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Remaining seven bits of A5 after the leading 1, plus its parity bit.
    task automatic send_word_tail();
        for (int i = 6; i >= 0; i--) bit1(8'hA5 >> i);
        if (PAR) begin
            if (early_chk) chk("no_valid_before_parity", valid_a, 1'b0);
            bit1(1'b0);
        end
    endtask

endmodule
